// File: rtl/glb_core_pcfg_sink.sv
// glb_core_pcfg_sink: far-end sink of the GLB tile PC packet path.
// Unpacks each 64-bit packet word into one CGRA config write
// {addr = rd_data[63:32], data = rd_data[31:0]}, counts issued writes
// against a target latched at start, and reports done / overflow.
// Optional skid FIFO: define GLB_PCFG_SKID_FIFO_EN. Without it, packets load
// the output register directly and a packet arriving under stall only flags
// overflow.

typedef struct packed {
  logic [63:0] rd_data;
  logic        rd_data_valid;
} rd_packet_t;

module glb_core_pcfg_sink #(
  parameter int unsigned CFG_ADDR_WIDTH = 32,
  parameter int unsigned CFG_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = 20
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  rd_packet_t                packet_pcr2sink,
  input  logic                      pcfg_start_pulse,
  input  logic [CNT_WIDTH-1:0]      cfg_pcfg_num_cfg,
  input  logic                      cgra_cfg_stall,
  output logic                      cgra_cfg_wr_en,
  output logic [CFG_ADDR_WIDTH-1:0] cgra_cfg_addr,
  output logic [CFG_DATA_WIDTH-1:0] cgra_cfg_data,
  output logic                      pcfg_busy,
  output logic                      pcfg_done_pulse,
  output logic                      pcfg_overflow
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("glb_core_pcfg_sink: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      target_q, target_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      wr_en_q;
  logic [CFG_ADDR_WIDTH-1:0] addr_q;
  logic [CFG_DATA_WIDTH-1:0] data_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      start_acc;
  logic                      run_open;
  logic                      in_v;
  logic                      issue;
  logic                      drop;
  logic [63:0]               issue_word;

  // Start is honoured only from IDLE; writes are accepted only while RUN has budget left.
  always_comb begin
    start_acc = (state_q == IDLE) && pcfg_start_pulse;
    run_open  = (state_q == RUN) && (cnt_q != target_q);
    in_v      = run_open && packet_pcr2sink.rd_data_valid;
  end

`ifdef GLB_PCFG_SKID_FIFO_EN
  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Skid FIFO control; an empty FIFO is bypassed so an unstalled packet issues with 1-cycle latency.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    issue      = run_open && !cgra_cfg_stall && (!empty || in_v);
    issue_word = empty ? packet_pcr2sink.rd_data : mem_q[rd_ptr_q[IDX_W-1:0]];
    pop        = issue && !empty;
    push       = in_v && !(issue && empty) && (!full || pop);
    drop       = in_v && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (start_acc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO pointers; reset and start both flush the contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= packet_pcr2sink.rd_data;
  end
`else
  // Direct path: every accepted packet issues; a packet under stall is flagged but still issued.
  always_comb begin
    issue      = in_v;
    issue_word = packet_pcr2sink.rd_data;
    drop       = in_v && cgra_cfg_stall;
  end
`endif

  // Run FSM next state: IDLE -> RUN on start, RUN -> DONE once the count hits target, DONE for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pcfg_start_pulse) state_d = RUN;
      RUN:     if (cnt_q == target_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Target latch, issue counter and sticky overflow next-state.
  always_comb begin
    target_d = target_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | drop;
    if (start_acc) begin
      target_d = cfg_pcfg_num_cfg;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else if (issue) begin
      cnt_d    = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_en_q  <= issue;
      if (issue) begin
        addr_q <= issue_word[CFG_DATA_WIDTH +: CFG_ADDR_WIDTH];
        data_q <= issue_word[CFG_DATA_WIDTH-1:0];
      end
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign cgra_cfg_wr_en  = wr_en_q;
  assign cgra_cfg_addr   = addr_q;
  assign cgra_cfg_data   = data_q;
  assign pcfg_busy       = busy_q;
  assign pcfg_done_pulse = done_q;
  assign pcfg_overflow   = ovf_q;

endmodule

// File: tb/tb_glb_core_pcfg_sink.sv
// Testbench for glb_core_pcfg_sink: per-cycle vector table for control
// outputs, plus a write scoreboard for addr/data ordering, plus a hand-written
// mid-run reset sequence. Expectations follow GLB_PCFG_SKID_FIFO_EN.

module tb_glb_core_pcfg_sink;

`ifdef GLB_PCFG_SKID_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [63:0] pkt_data;
  logic        pkt_vld;
  logic        start;
  logic [19:0] num_cfg;
  logic        stall;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        ovf;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          mon_en = 1'b1;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        start;
    logic [19:0] num;
    logic        vld;
    logic [63:0] data;
    logic        stall;
    logic        acc;   // packet expected to be written out eventually
    logic [3:0]  e;     // expected {wr_en, busy, done, overflow} in this cycle
  } vec_t;

  vec_t tbl[$];

  glb_core_pcfg_sink #(
    .CFG_ADDR_WIDTH(32),
    .CFG_DATA_WIDTH(32),
    .FIFO_DEPTH    (4),
    .CNT_WIDTH     (20)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .packet_pcr2sink ({pkt_data, pkt_vld}),
    .pcfg_start_pulse(start),
    .cfg_pcfg_num_cfg(num_cfg),
    .cgra_cfg_stall  (stall),
    .cgra_cfg_wr_en  (wr_en),
    .cgra_cfg_addr   (addr),
    .cgra_cfg_data   (data),
    .pcfg_busy       (busy),
    .pcfg_done_pulse (done),
    .pcfg_overflow   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic [19:0] n, input logic v,
                     input logic [63:0] d, input logic sl, input logic a,
                     input logic [3:0] e);
    vec_t r;
    r.start = st; r.num = n; r.vld = v; r.data = d; r.stall = sl; r.acc = a; r.e = e;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] w(input logic [31:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  function automatic logic [3:0] sel(input logic [3:0] with_fifo, input logic [3:0] without);
    return FIFO_EN ? with_fifo : without;
  endfunction

  // Write scoreboard: every strobe must match the oldest expected word.
  always @(posedge clk) begin
    #2;
    if (mon_en && wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got=%h expected=none", {addr, data});
      end else begin
        logic [63:0] ew;
        ew = exp_q.pop_front();
        if ({addr, data} !== ew) begin
          errors++;
          $display("FAIL write_data: got=%h expected=%h", {addr, data}, ew);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; pkt_data = '0; pkt_vld = 1'b0; start = 1'b0; num_cfg = '0; stall = 1'b0;

    // Block A: idle packet, num_cfg=3 run, start ignored in RUN/DONE, late packets dropped
    add(0, 0, 1, w(32'hDEAD0000, 32'h00000001), 0, 0, 4'b0000);
    add(1, 3, 0, '0, 0, 0, 4'b0000);
    add(0, 0, 1, w(32'h00000010, 32'hAAAA0001), 0, 1, 4'b0100);
    add(0, 0, 1, w(32'h00000010, 32'hAAAA0002), 0, 1, 4'b1100);
    add(1, 0, 1, w(32'h00000010, 32'hAAAA0003), 0, 1, 4'b1100);
    add(0, 0, 1, w(32'h00000010, 32'hAAAA0004), 0, 0, 4'b1100);
    add(1, 5, 1, w(32'h00000010, 32'hAAAA0005), 0, 0, 4'b0010);
    add(0, 0, 0, '0, 0, 0, 4'b0000);
    add(0, 0, 0, '0, 0, 0, 4'b0000);
    // Block B: num_cfg=0 completes without writes
    add(1, 0, 0, '0, 0, 0, 4'b0000);
    add(0, 0, 0, '0, 0, 0, 4'b0100);
    add(0, 0, 0, '0, 0, 0, 4'b0010);
    add(0, 0, 0, '0, 0, 0, 4'b0000);
    // Block C: num_cfg=8, stall 6 cycles with 4 packets, then 4 unstalled packets
    add(1, 8, 0, '0, 0, 0, 4'b0000);
    add(0, 0, 1, w(32'h00000101, 32'hBBBB0001), 1, 1, 4'b0100);
    add(0, 0, 1, w(32'h00000102, 32'hBBBB0002), 1, 1, sel(4'b0100, 4'b1101));
    add(0, 0, 1, w(32'h00000103, 32'hBBBB0003), 1, 1, sel(4'b0100, 4'b1101));
    add(0, 0, 1, w(32'h00000104, 32'hBBBB0004), 1, 1, sel(4'b0100, 4'b1101));
    add(0, 0, 0, '0, 1, 0, sel(4'b0100, 4'b1101));
    add(0, 0, 0, '0, 1, 0, sel(4'b0100, 4'b0101));
    add(0, 0, 0, '0, 0, 0, sel(4'b0100, 4'b0101));
    add(0, 0, 0, '0, 0, 0, sel(4'b1100, 4'b0101));
    add(0, 0, 0, '0, 0, 0, sel(4'b1100, 4'b0101));
    add(0, 0, 0, '0, 0, 0, sel(4'b1100, 4'b0101));
    add(0, 0, 0, '0, 0, 0, sel(4'b1100, 4'b0101));
    add(0, 0, 1, w(32'h00000105, 32'hBBBB0005), 0, 1, sel(4'b0100, 4'b0101));
    add(0, 0, 1, w(32'h00000106, 32'hBBBB0006), 0, 1, sel(4'b1100, 4'b1101));
    add(0, 0, 1, w(32'h00000107, 32'hBBBB0007), 0, 1, sel(4'b1100, 4'b1101));
    add(0, 0, 1, w(32'h00000108, 32'hBBBB0008), 0, 1, sel(4'b1100, 4'b1101));
    add(0, 0, 0, '0, 0, 0, sel(4'b1100, 4'b1101));
    add(0, 0, 0, '0, 0, 0, sel(4'b0010, 4'b0011));
    add(0, 0, 0, '0, 0, 0, sel(4'b0000, 4'b0001));
    // Block D: num_cfg=4, stall held over 5 packets
    add(1, 4, 0, '0, 0, 0, sel(4'b0000, 4'b0001));
    add(0, 0, 1, w(32'h00000201, 32'hCCCC0001), 1, 1, 4'b0100);
    add(0, 0, 1, w(32'h00000202, 32'hCCCC0002), 1, 1, sel(4'b0100, 4'b1101));
    add(0, 0, 1, w(32'h00000203, 32'hCCCC0003), 1, 1, sel(4'b0100, 4'b1101));
    add(0, 0, 1, w(32'h00000204, 32'hCCCC0004), 1, 1, sel(4'b0100, 4'b1101));
    add(0, 0, 1, w(32'h00000205, 32'hCCCC0005), 1, 0, sel(4'b0100, 4'b1101));
    add(0, 0, 0, '0, 0, 0, sel(4'b0101, 4'b0011));
    add(0, 0, 0, '0, 0, 0, sel(4'b1101, 4'b0001));
    add(0, 0, 0, '0, 0, 0, sel(4'b1101, 4'b0001));
    add(0, 0, 0, '0, 0, 0, sel(4'b1101, 4'b0001));
    add(0, 0, 0, '0, 0, 0, sel(4'b1101, 4'b0001));
    add(0, 0, 0, '0, 0, 0, sel(4'b0011, 4'b0001));
    add(0, 0, 0, '0, 0, 0, 4'b0001);
    // Block E: next start clears overflow
    add(1, 0, 0, '0, 0, 0, 4'b0001);
    add(0, 0, 0, '0, 0, 0, 4'b0100);
    add(0, 0, 0, '0, 0, 0, 4'b0010);
    add(0, 0, 0, '0, 0, 0, 4'b0000);

    #12;
    check("reset_outputs", {56'd0, wr_en, busy, done, ovf, 4'd0}, 64'd0);
    check("reset_addr_data", {addr, data}, 64'd0);
    #1 reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step();
      checks++;
      if ({wr_en, busy, done, ovf} !== tbl[i].e) begin
        errors++;
        $display("FAIL vec[%0d] {wr,busy,done,ovf}: got=%b expected=%b", i,
                 {wr_en, busy, done, ovf}, tbl[i].e);
      end
      start    = tbl[i].start;
      num_cfg  = tbl[i].num;
      pkt_vld  = tbl[i].vld;
      pkt_data = tbl[i].data;
      stall    = tbl[i].stall;
      if (tbl[i].vld && tbl[i].acc) exp_q.push_back(tbl[i].data);
    end
    step();
    start = 1'b0; pkt_vld = 1'b0; stall = 1'b0;
    check("table_writes_drained", 64'(exp_q.size()), 64'd0);

    // Mid-run reset with two words in flight, then a clean num_cfg=1 run
    mon_en = 1'b0;
    start = 1'b1; num_cfg = 20'd4;
    step();
    start = 1'b0; stall = 1'b1; pkt_vld = 1'b1; pkt_data = w(32'h00000301, 32'hDDDD0001);
    step();
    pkt_data = w(32'h00000302, 32'hDDDD0002);
    step();
    pkt_vld = 1'b0;
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", {60'd0, wr_en, busy, done, ovf}, 64'd0);
    check("midrun_reset_addr_data", {addr, data}, 64'd0);
    @(posedge clk);
    #3 reset_n = 1'b1; stall = 1'b0;
    mon_en = 1'b1;
    step();
    start = 1'b1; num_cfg = 20'd1;
    step();
    start = 1'b0;
    check("post_reset_run_entry", {61'd0, wr_en, busy, done}, 64'b010);
    pkt_vld = 1'b1; pkt_data = w(32'h00000401, 32'hEEEE0001);
    exp_q.push_back(pkt_data);
    step();
    pkt_vld = 1'b0;
    check("post_reset_write", {61'd0, wr_en, busy, done}, 64'b110);
    step();
    check("post_reset_done", {60'd0, wr_en, busy, done, ovf}, 64'b0010);
    step();
    check("post_reset_idle", {60'd0, wr_en, busy, done, ovf}, 64'b0000);
    step();
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glb_core_pcfg_sink.md
# glb_core_pcfg_sink

Parallel-configuration packet sink at the far end of the GLB tile PC packet path. It accepts the read packets the PC router delivers toward the CGRA and unpacks each 64-bit word into one CGRA configuration write (`{addr[31:0], data[31:0]}`). It buffers words in a small skid FIFO so the configuration bus can be stalled, counts the issued writes against a programmed total, and reports completion and overflow to the tile controller.

## Interface
Parameters:
- CFG_ADDR_WIDTH, 32, CGRA config address width (upper half of rd_data)
- CFG_DATA_WIDTH, 32, CGRA config data width (lower half of rd_data)
- FIFO_DEPTH, 4, skid FIFO entries, power of two, ≥2
- CNT_WIDTH, 20, width of config-word counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- packet_pcr2sink  in  rd_packet_t  packet from PC router; fields rd_data (64), rd_data_valid (1)
- pcfg_start_pulse  in  1  one-cycle start of a configuration run
- cfg_pcfg_num_cfg  in  CNT_WIDTH  number of config writes in the run, sampled at start
- cgra_cfg_stall  in  1  CGRA config bus cannot take a write this cycle
- cgra_cfg_wr_en  out  1  config write strobe
- cgra_cfg_addr  out  CFG_ADDR_WIDTH  config address
- cgra_cfg_data  out  CFG_DATA_WIDTH  config data
- pcfg_busy  out  1  high in RUN
- pcfg_done_pulse  out  1  one-cycle completion pulse
- pcfg_overflow  out  1  sticky: a valid packet was dropped because the FIFO was full

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE → RUN on pcfg_start_pulse. On that edge:
  - the target is latched from cfg_pcfg_num_cfg;
  - the issue counter is cleared;
  - the FIFO is flushed;
  - pcfg_overflow is cleared.
- If the latched target is 0, the FSM goes RUN → DONE on the next edge with no writes.
- RUN: each packet with rd_data_valid=1 is pushed into the FIFO.
  - Pop when the FIFO is non-empty and cgra_cfg_stall=0.
  - A pop drives the registered outputs next cycle: wr_en=1, addr=rd_data[63:32], data=rd_data[31:0]. The issue counter increments.
- RUN → DONE on the edge where the issued count reaches the target. DONE lasts exactly one cycle (pcfg_done_pulse=1), then goes to IDLE.
- Packets arriving after the target is reached, or in IDLE/DONE, are discarded. They do not set overflow.
- pcfg_start_pulse in RUN or DONE is ignored.
- When the FIFO is full and a packet arrives:
  - with a pop in the same cycle, the push is accepted;
  - without a pop, the packet is dropped and pcfg_overflow is set. It stays set until the next accepted start or reset.
- Arithmetic:
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - full = same index with MSB differing; empty = pointers equal.
  - The counter compares with equality and never wraps within a run.
- Reset mid-run immediately forces IDLE, empties the FIFO and clears all outputs.

## Timing
- Reset values: cgra_cfg_wr_en=0, cgra_cfg_addr=0, cgra_cfg_data=0, pcfg_busy=0, pcfg_done_pulse=0, pcfg_overflow=0.
- Packet valid in cycle t with an empty FIFO and no stall gives cgra_cfg_wr_en=1 in cycle t+1 (1-cycle latency).
- Stall seen in cycle t suppresses the pop at edge t, so cgra_cfg_wr_en=0 in t+1. Data is held in the FIFO.
- The last write appears in cycle t+1 and pcfg_done_pulse appears in cycle t+2. pcfg_busy deasserts in the same cycle as done.
- All outputs are registered.

## Configuration
- GLB_PCFG_SKID_FIFO_EN defined: behaviour as above, FIFO of FIFO_DEPTH entries.
- GLB_PCFG_SKID_FIFO_EN undefined:
  - no FIFO; the output register is loaded directly from a valid packet in RUN;
  - cgra_cfg_stall has no effect on issue;
  - any valid packet in RUN while cgra_cfg_stall=1 sets pcfg_overflow. That packet is still issued.
  - Latency stays 1 cycle.

## Test plan
- Start with num_cfg=3, then 3 back-to-back packets 0x00000010_AAAA0001..3: wr_en high in cycles t+1..t+3 with matching addr/data; done pulse at t+4; busy low at t+4.
- Start with num_cfg=0: done pulse the cycle after RUN entry, no wr_en.
- num_cfg=8, stall high for 6 cycles while 4 packets arrive: no writes during stall, no overflow; after release, 4 writes in order on consecutive cycles.
- Stall held while 5 packets arrive (DEPTH=4): 5th dropped, pcfg_overflow=1 sticky; 4 writes issued after release; overflow clears on next start.
- Packet in IDLE and a 4th packet after num_cfg=3 is reached: both ignored, no wr_en, no overflow.
- Assert reset_n low mid-run with 2 words queued: outputs 0 immediately; after release, new start with num_cfg=1 completes normally.
